// File: rtl/riscv_pkg.sv
// Shared fetch definitions: machine widths, fetch FSM encoding and small
// helpers used when selecting instruction words from memory doublewords.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

  // Memory returns a full doubleword; pc[2] picks which 32-bit half holds
  // the instruction (little-endian: the lower address is the low half).
  function automatic logic [ILEN-1:0] select_word(input logic [XLEN-1:0] dword,
                                                  input logic            upper);
    return upper ? dword[XLEN-1:ILEN] : dword[ILEN-1:0];
  endfunction

  // Instruction addresses must be 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] lo_bits);
    return lo_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues doubleword reads for the current PC,
// hands one 32-bit instruction at a time to decode, and follows redirects
// from later stages. A redirect that arrives while a read is outstanding
// cannot cancel the read, so the response is dropped via a squash flag.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter logic [ILEN-1:0] HALT_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [ILEN-1:0] instr_reg,
  output logic [XLEN-1:0] ifid_npc,
  output logic            data_ack,
  output logic            halted,
  output logic            fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] squash_pc_q, squash_pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] pc_plus4;
  logic            redirect_bad;

  // PC increment wraps naturally at 2^64.
  assign pc_plus4     = pc_q + 64'd4;
  // A misaligned target is fatal in every state except HALT, where
  // redirects are ignored altogether.
  assign redirect_bad = redirect_valid && misaligned(redirect_pc[1:0]) &&
                        (state_q != ST_HALT);

  // Next-state and datapath-update logic for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    squash_pc_d = squash_pc_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;

    if (redirect_bad) begin
      // Abandon whatever is in flight and stop for good.
      state_d  = ST_HALT;
      halted_d = 1'b1;
      fault_d  = 1'b1;
      squash_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Any mem_ack seen here belongs to a request killed by reset.
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end
          state_d = ST_FETCH;
        end

        ST_FETCH: begin
          if (mem_ack) begin
            if (redirect_valid) begin
              // Response is for the old path; restart at the new target.
              pc_d     = redirect_pc;
              squash_d = 1'b0;
            end else if (squash_q) begin
              // Drop the stale response and move to the latched target.
              pc_d     = squash_pc_q;
              squash_d = 1'b0;
            end else begin
              instr_d = select_word(mem_rdata, pc_q[2]);
              npc_d   = pc_plus4;
              state_d = ST_DELIVER;
            end
          end else if (redirect_valid) begin
            // Request must stay stable; remember the target (latest wins).
            squash_d    = 1'b1;
            squash_pc_d = redirect_pc;
          end
        end

        ST_DELIVER: begin
          if (redirect_valid) begin
            // Redirect outranks both stall and halt detection.
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end else if (!stall) begin
            if (instr_q == HALT_INSTR) begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end else begin
              pc_d    = pc_plus4;
              state_d = ST_FETCH;
            end
          end
        end

        ST_HALT: begin
          // Only reset leaves HALT.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      squash_pc_q <= '0;
      instr_q     <= '0;
      npc_q       <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      squash_pc_q <= squash_pc_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  // Request and handshake outputs decode straight from the registered state,
  // so they stay glitch-free and hold steady for the whole FETCH wait.
  assign mem_req   = (state_q == ST_FETCH);
  assign mem_addr  = mem_req ? {pc_q[XLEN-1:3], 3'b000} : '0;
  assign data_ack  = (state_q == ST_DELIVER);
  assign instr_reg = instr_q;
  assign ifid_npc  = npc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table for the basic fetch/halt
// flow plus hand-written sequences for stall, redirect and fault/reset.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic [31:0] instr_reg;
  logic [63:0] ifid_npc;
  logic        data_ack;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h0), .HALT_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr_reg(instr_reg), .ifid_npc(ifid_npc),
    .data_ack(data_ack), .halted(halted), .fault(fault)
  );

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        st;
    logic        ack;
    logic [63:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_dack;
    logic        chk_data;
    logic [31:0] e_instr;
    logic [63:0] e_npc;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  localparam logic [63:0] D0 = 64'h0000_0000_0050_0093;
  localparam logic [63:0] RW = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] ST = 64'hDEAD_BEEF_1234_5678;

  function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic st,
                              input logic ack, input logic [63:0] rdata,
                              input logic e_req, input logic [63:0] e_addr,
                              input logic e_dack, input logic chk_data,
                              input logic [31:0] e_instr, input logic [63:0] e_npc,
                              input logic e_halt, input logic e_fault);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.st = st; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_dack = e_dack; v.chk_data = chk_data;
    v.e_instr = e_instr; v.e_npc = e_npc; v.e_halt = e_halt; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic [63:0] rpc, input logic st,
                        input logic ack, input logic [63:0] rdata);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    mem_ack        = ack;
    mem_rdata      = rdata;
  endtask

  task automatic chk_ctl(input string tag, input logic req, input logic [63:0] addr,
                         input logic dack, input logic hlt, input logic flt);
    chk({tag, ".mem_req"},  {63'd0, mem_req},  {63'd0, req});
    chk({tag, ".mem_addr"}, mem_addr,          addr);
    chk({tag, ".data_ack"}, {63'd0, data_ack}, {63'd0, dack});
    chk({tag, ".halted"},   {63'd0, halted},   {63'd0, hlt});
    chk({tag, ".fault"},    {63'd0, fault},    {63'd0, flt});
  endtask

  task automatic chk_data(input string tag, input logic [31:0] ins, input logic [63:0] npc);
    chk({tag, ".instr_reg"}, {32'd0, instr_reg}, {32'd0, ins});
    chk({tag, ".ifid_npc"},  ifid_npc,           npc);
  endtask

  // Hold reset for two cycles, check reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    set_in(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_ctl({tag, ".rst"}, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk_data({tag, ".rst"}, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);

    //            rv  rpc       st  ack  rdata  req addr   dack chk instr         npc    hlt flt
    vecs[0]  = mk(0, 64'h0,    0,  0,  64'h0, 0, 64'h0, 0,   1,  32'h0,        64'h0, 0,  0);
    vecs[1]  = mk(0, 64'h0,    0,  0,  64'h0, 1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[2]  = mk(0, 64'h0,    0,  0,  64'h0, 1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[3]  = mk(0, 64'h0,    0,  1,  D0,    1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[4]  = mk(0, 64'h0,    0,  0,  64'h0, 0, 64'h0, 1,   1,  32'h00500093, 64'h4, 0,  0);
    vecs[5]  = mk(0, 64'h0,    0,  0,  64'h0, 1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[6]  = mk(0, 64'h0,    0,  0,  64'h0, 1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[7]  = mk(0, 64'h0,    0,  1,  D0,    1, 64'h0, 0,   0,  32'h0,        64'h0, 0,  0);
    vecs[8]  = mk(0, 64'h0,    0,  0,  64'h0, 0, 64'h0, 1,   1,  32'h0,        64'h8, 0,  0);
    vecs[9]  = mk(1, 64'h202,  0,  1,  D0,    0, 64'h0, 0,   0,  32'h0,        64'h0, 1,  0);
    vecs[10] = mk(1, 64'h300,  0,  0,  64'h0, 0, 64'h0, 0,   0,  32'h0,        64'h0, 1,  0);
    vecs[11] = mk(0, 64'h0,    0,  0,  64'h0, 0, 64'h0, 0,   0,  32'h0,        64'h0, 1,  0);

    // Basic fetch / deliver / halt flow, one table row per cycle.
    do_reset("tbl");
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("tbl[%0d]", i);
      chk_ctl(tag, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_dack,
              vecs[i].e_halt, vecs[i].e_fault);
      if (vecs[i].chk_data) chk_data(tag, vecs[i].e_instr, vecs[i].e_npc);
      set_in(vecs[i].rv, vecs[i].rpc, vecs[i].st, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
    end

    // Stall holds the delivered instruction; fetch resumes at pc 0x4.
    do_reset("stl");
    @(negedge clk);
    set_in(0, 64'h0, 0, 1, D0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("stl.hold%0d", i), 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk_data($sformatf("stl.hold%0d", i), 32'h00500093, 64'h4);
      set_in(0, 64'h0, (i < 3), 0, 64'h0);
      @(negedge clk);
    end
    chk_ctl("stl.refetch", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, D0);
    @(negedge clk);
    chk_ctl("stl.dlv2", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_data("stl.dlv2", 32'h0, 64'h8);

    // Redirect before ack drops the stale word; word select by pc[2].
    do_reset("rdr");
    @(negedge clk);
    chk_ctl("rdr.f0", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    set_in(1, 64'h100, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("rdr.hold", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, ST);
    @(negedge clk);
    chk_ctl("rdr.f100", 1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, RW);
    @(negedge clk);
    chk_ctl("rdr.d100", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_data("rdr.d100", 32'hCCCCDDDD, 64'h104);
    set_in(0, 64'h0, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("rdr.f104", 1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, RW);
    @(negedge clk);
    chk_data("rdr.d104", 32'hAAAABBBB, 64'h108);
    // Redirect in DELIVER beats stall.
    set_in(1, 64'h200, 1, 0, 64'h0);
    @(negedge clk);
    chk_ctl("rdr.f200", 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    set_in(1, 64'h300, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("rdr.sq1", 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    set_in(1, 64'h400, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("rdr.sq2", 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, ST);
    @(negedge clk);
    chk_ctl("rdr.f400", 1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
    // Redirect coinciding with ack.
    set_in(1, 64'h500, 0, 1, ST);
    @(negedge clk);
    chk_ctl("rdr.f500", 1'b1, 64'h500, 1'b0, 1'b0, 1'b0);
    set_in(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, ST);
    @(negedge clk);
    chk_ctl("rdr.ftop", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 1, RW);
    @(negedge clk);
    chk_ctl("rdr.dtop", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_data("rdr.wrap", 32'hAAAABBBB, 64'h0);

    // Misaligned redirect faults; async reset clears; reset kills a request.
    do_reset("flt");
    @(negedge clk);
    set_in(1, 64'h102, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("flt.set", 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    set_in(0, 64'h0, 0, 1, D0);
    @(negedge clk);
    chk_ctl("flt.stay", 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    set_in(0, 64'h0, 0, 0, 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_ctl("flt.async", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_ctl("abn.f0", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 64'h0, 0, 1, D0);
    @(negedge clk);
    chk_ctl("abn.f1", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    set_in(0, 64'h0, 0, 0, 64'h0);
    @(negedge clk);
    chk_ctl("abn.f2", 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
